// File: rtl/ws281x_ctrl.sv
// rtl/ws281x_ctrl.sv - WS281x frame sequencer: pixel fetch, bit serializer, latch period
//
// Reads pixels from a 24-bit pixel RAM, serializes each MSB-first as a
// high/low waveform using T0/T1 cycle counts, then holds the line for a
// latch period and pulses done_o.
// Build macro WS281X_CTRL_DOUT_INV_EN: when defined, dout_o is driven inverted.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 frame start pulse, accepted only while idle
//   pix_cnt_i               pixels per frame (sampled on start, clamped to 2^ADDR_W)
//   rst_cnt_i               latch low cycles (sampled on start, 0 acts as 1)
//   t0h_cnt_i, t0s_cnt_i    '0' bit high cycles / period cycles
//   t1h_cnt_i, t1s_cnt_i    '1' bit high cycles / period cycles
//   rd_en_o, rd_addr_o      pixel RAM read strobe / address
//   rd_data_i               pixel RAM data, valid one cycle after rd_en_o
//   dout_o                  LED data line
//   busy_o, done_o          frame in progress / one-cycle completion pulse
module ws281x_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   pix_cnt_i,
  input  logic [7:0]        t0h_cnt_i,
  input  logic [7:0]        t0s_cnt_i,
  input  logic [7:0]        t1h_cnt_i,
  input  logic [7:0]        t1s_cnt_i,
  input  logic [15:0]       rst_cnt_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [23:0]       rd_data_i,
  output logic              dout_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0] MAX_PIX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PIX_ONE = {{ADDR_W{1'b0}}, 1'b1};
`ifdef WS281X_CTRL_DOUT_INV_EN
  localparam logic DOUT_INV = 1'b1;
`else
  localparam logic DOUT_INV = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_BIT, S_LATCH} state_t;
  state_t r_state, w_state_nxt;

  logic [ADDR_W:0]   r_npix, r_pix;
  logic [15:0]       r_rcnt, r_lcnt;
  logic [22:0]       r_shift;      // bits of the current pixel not yet started
  logic [23:0]       r_shadow;     // prefetched next pixel
  logic              r_pend;       // RAM data arrives this cycle
  logic [4:0]        r_bit;
  logic [7:0]        r_cnt;        // cycle index within current bit
  logic [8:0]        r_th, r_p;    // high cycles / period of current bit
  logic              r_rd_en, r_dout, r_busy, r_done;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_start, w_bit_end, w_last_bit, w_more, w_sel_bit;
  logic [ADDR_W:0]   w_pix_nxt, w_npix_eff;
  logic [15:0]       w_rst_eff, w_lcnt_nxt;
  logic [23:0]       w_next_pix;
  logic [7:0]        w_th_raw, w_ts_raw;
  logic [8:0]        w_th_sel, w_ts_sel, w_p_sel;
  logic              w_rd_en_nxt, w_dout_nxt, w_busy_nxt, w_done_nxt;
  logic [ADDR_W-1:0] w_rd_addr_nxt;

  assign w_start    = (r_state == S_IDLE) && start_i;
  assign w_npix_eff = (pix_cnt_i > MAX_PIX) ? MAX_PIX : pix_cnt_i;
  assign w_rst_eff  = (rst_cnt_i == 16'd0) ? 16'd1 : rst_cnt_i;
  assign w_bit_end  = (r_state == S_BIT) && ({1'b0, r_cnt} == (r_p - 9'd1));
  assign w_last_bit = (r_bit == 5'd0);
  assign w_pix_nxt  = r_pix + PIX_ONE;
  assign w_more     = (w_pix_nxt < r_npix);
  // With a 2-cycle last bit the prefetched word lands on the pixel boundary
  // itself, so it must bypass the shadow register.
  assign w_next_pix = r_pend ? rd_data_i : r_shadow;

  // Value of the bit about to start; its timing is latched at that edge.
  always_comb begin
    w_sel_bit = r_shift[22];
    if (r_state == S_WAIT)
      w_sel_bit = rd_data_i[23];
    else if (w_last_bit)
      w_sel_bit = w_next_pix[23];
  end

  assign w_th_raw = w_sel_bit ? t1h_cnt_i : t0h_cnt_i;
  assign w_ts_raw = w_sel_bit ? t1s_cnt_i : t0s_cnt_i;
  assign w_th_sel = (w_th_raw == 8'd0) ? 9'd1 : {1'b0, w_th_raw};
  assign w_ts_sel = {1'b0, w_ts_raw};
  // Period always leaves at least one low cycle.
  assign w_p_sel  = (w_ts_sel > w_th_sel) ? w_ts_sel : (w_th_sel + 9'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = (pix_cnt_i == '0) ? S_LATCH : S_FETCH;
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_BIT;
      S_BIT:   if (w_bit_end && w_last_bit && !w_more) w_state_nxt = S_LATCH;
      S_LATCH: if (r_lcnt == 16'd1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_dout_nxt    = 1'b0;
    w_lcnt_nxt    = r_lcnt;
    case (r_state)
      S_IDLE: begin
        if (w_start && (pix_cnt_i != '0)) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = '0;
        end
        if (w_start) w_lcnt_nxt = w_rst_eff;
      end
      S_WAIT: w_dout_nxt = 1'b1;
      S_BIT: begin
        if (!w_bit_end) begin
          w_dout_nxt = (({1'b0, r_cnt} + 9'd1) < r_th);
        end else begin
          w_dout_nxt = !w_last_bit || w_more;
          if (w_last_bit && !w_more) w_lcnt_nxt = r_rcnt;
        end
        // Prefetch as the last bit of this pixel starts.
        if (w_bit_end && (r_bit == 5'd1) && w_more) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = w_pix_nxt[ADDR_W-1:0];
        end
      end
      S_LATCH: w_lcnt_nxt = r_lcnt - 16'd1;
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_LATCH) && (w_lcnt_nxt == 16'd1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_dout    <= DOUT_INV;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_dout    <= w_dout_nxt ^ DOUT_INV;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_npix   <= '0;
      r_pix    <= '0;
      r_rcnt   <= 16'd0;
      r_lcnt   <= 16'd0;
      r_shift  <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_bit    <= 5'd0;
      r_cnt    <= 8'd0;
      r_th     <= 9'd0;
      r_p      <= 9'd0;
    end else begin
      r_lcnt <= w_lcnt_nxt;
      r_pend <= r_rd_en;
      if (r_pend) r_shadow <= rd_data_i;
      if (w_start) begin
        r_npix <= w_npix_eff;
        r_rcnt <= w_rst_eff;
        r_pix  <= '0;
      end
      if (r_state == S_WAIT) begin
        r_shift <= rd_data_i[22:0];
        r_bit   <= 5'd23;
        r_cnt   <= 8'd0;
        r_th    <= w_th_sel;
        r_p     <= w_p_sel;
      end else if (r_state == S_BIT) begin
        if (!w_bit_end) begin
          r_cnt <= r_cnt + 8'd1;
        end else if (!w_last_bit) begin
          r_shift <= {r_shift[21:0], 1'b0};
          r_bit   <= r_bit - 5'd1;
          r_cnt   <= 8'd0;
          r_th    <= w_th_sel;
          r_p     <= w_p_sel;
        end else if (w_more) begin
          r_pix   <= w_pix_nxt;
          r_shift <= w_next_pix[22:0];
          r_bit   <= 5'd23;
          r_cnt   <= 8'd0;
          r_th    <= w_th_sel;
          r_p     <= w_p_sel;
        end
      end
    end
  end

  assign rd_en_o   = r_rd_en;
  assign rd_addr_o = r_rd_addr;
  assign dout_o    = r_dout;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule

// File: tb/tb_ws281x_ctrl.sv
// tb/tb_ws281x_ctrl.sv - directed self-checking bench for ws281x_ctrl
module tb_ws281x_ctrl;

  localparam int ADDR_W = 8;
  localparam int MAXC   = 13000;
`ifdef WS281X_CTRL_DOUT_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [ADDR_W:0]   pix_cnt_i = '0;
  logic [7:0]        t0h_cnt_i = 8'd0, t0s_cnt_i = 8'd0, t1h_cnt_i = 8'd0, t1s_cnt_i = 8'd0;
  logic [15:0]       rst_cnt_i = 16'd0;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [23:0]       rd_data_i;
  logic              dout_o, busy_o, done_o;

  logic [23:0] mem [0:255];
  logic rec_dout [0:MAXC];
  logic rec_busy [0:MAXC];
  logic rec_done [0:MAXC];
  logic rec_rden [0:MAXC];
  int   rd_cyc[$];
  int   rd_adr[$];
  int   n_chk = 0;
  int   n_pass = 0;

  ws281x_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pix_cnt_i(pix_cnt_i),
    .t0h_cnt_i(t0h_cnt_i), .t0s_cnt_i(t0s_cnt_i), .t1h_cnt_i(t1h_cnt_i), .t1s_cnt_i(t1s_cnt_i),
    .rst_cnt_i(rst_cnt_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .dout_o(dout_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Pixel RAM: data valid only in the cycle after a read strobe.
  always @(posedge clk_i) rd_data_i <= rd_en_o ? mem[rd_addr_o] : 24'h5A5A5A;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_timing(input int a, input int b, input int c, input int d);
    t0h_cnt_i = a[7:0]; t0s_cnt_i = b[7:0]; t1h_cnt_i = c[7:0]; t1s_cnt_i = d[7:0];
  endtask

  // Cycle 1 is the cycle after the edge that samples start. Extra start
  // pulses are driven during cycles s1..s3 (0 = unused).
  task automatic run_frame(input int pix, input int rc, input int budget,
                           input int s1, input int s2, input int s3, output int dcyc);
    pix_cnt_i = pix[ADDR_W:0];
    rst_cnt_i = rc[15:0];
    rd_cyc.delete();
    rd_adr.delete();
    dcyc = -1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= budget && c < MAXC; c++) begin
      rec_dout[c] = dout_o ^ INV;
      rec_busy[c] = busy_o;
      rec_done[c] = done_o;
      rec_rden[c] = rd_en_o;
      if (rd_en_o) begin
        rd_cyc.push_back(c);
        rd_adr.push_back(int'(rd_addr_o));
      end
      if (done_o && dcyc < 0) dcyc = c;
      if (dcyc > 0 && c >= dcyc + 2) break;
      start_i = (c == s1) || (c == s2) || (c == s3);
      tick();
    end
    start_i = 1'b0;
  endtask

  function automatic int count_high(input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) if (rec_dout[c] === 1'b1) s++;
    return s;
  endfunction

  task automatic test_reset();
    tick(); tick();
    n_chk++; if ((dout_o ^ INV) !== 1'b0) $display("FAIL reset_dout: got %b exp 0", dout_o ^ INV); else n_pass++;
    n_chk++; if (rd_en_o !== 1'b0) $display("FAIL reset_rd_en: got %b exp 0", rd_en_o); else n_pass++;
    n_chk++; if (rd_addr_o !== 8'd0) $display("FAIL reset_rd_addr: got %0d exp 0", rd_addr_o); else n_pass++;
    n_chk++; if ({busy_o, done_o} !== 2'b00) $display("FAIL reset_busy_done: got %b exp 00", {busy_o, done_o}); else n_pass++;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_one_pixel();
    int dc;
    mem[0] = 24'hA50000;
    set_timing(2, 6, 4, 6);
    run_frame(1, 10, 400, 0, 0, 0, dc);
    n_chk++; if (dc !== 156) $display("FAIL one_px_done_cycle: got %0d exp 156", dc); else n_pass++;
    n_chk++; if (rec_rden[1] !== 1'b1) $display("FAIL one_px_fetch: got %b exp 1", rec_rden[1]); else n_pass++;
    n_chk++; if (rd_cyc.size() !== 1) $display("FAIL one_px_reads: got %0d exp 1", rd_cyc.size()); else n_pass++;
    n_chk++; if ({rec_dout[2], rec_dout[3]} !== 2'b01) $display("FAIL one_px_rise: got %b exp 01", {rec_dout[2], rec_dout[3]}); else n_pass++;
    n_chk++; if (count_high(3, 8) !== 4 || rec_dout[7] !== 1'b0) $display("FAIL one_px_bit23: got %0d high exp 4", count_high(3, 8)); else n_pass++;
    n_chk++; if (count_high(9, 14) !== 2 || rec_dout[9] !== 1'b1 || rec_dout[11] !== 1'b0) $display("FAIL one_px_bit22: got %0d high exp 2", count_high(9, 14)); else n_pass++;
    n_chk++; if (count_high(3, 146) !== 56) $display("FAIL one_px_total_high: got %0d exp 56", count_high(3, 146)); else n_pass++;
    n_chk++; if (count_high(147, 156) !== 0) $display("FAIL one_px_latch_low: got %0d exp 0", count_high(147, 156)); else n_pass++;
    n_chk++; if ({rec_busy[156], rec_busy[157], rec_done[155], rec_done[157]} !== 4'b1000) $display("FAIL one_px_busy_done: got %b exp 1000", {rec_busy[156], rec_busy[157], rec_done[155], rec_done[157]}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dc, c1, c2, a1, a2;
    mem[0] = 24'h000001; mem[1] = 24'h800000; mem[2] = 24'hFFFFFF;
    set_timing(1, 3, 2, 3);
    run_frame(3, 4, 400, 0, 0, 0, dc);
    c1 = (rd_cyc.size() > 1) ? rd_cyc[1] : -1;
    a1 = (rd_adr.size() > 1) ? rd_adr[1] : -1;
    c2 = (rd_cyc.size() > 2) ? rd_cyc[2] : -1;
    a2 = (rd_adr.size() > 2) ? rd_adr[2] : -1;
    n_chk++; if (dc !== 222) $display("FAIL b2b_done_cycle: got %0d exp 222", dc); else n_pass++;
    n_chk++; if (rd_cyc.size() !== 3) $display("FAIL b2b_reads: got %0d exp 3", rd_cyc.size()); else n_pass++;
    n_chk++; if (c1 !== 72 || a1 !== 1) $display("FAIL b2b_prefetch1: got cyc %0d addr %0d exp 72/1", c1, a1); else n_pass++;
    n_chk++; if (c2 !== 144 || a2 !== 2) $display("FAIL b2b_prefetch2: got cyc %0d addr %0d exp 144/2", c2, a2); else n_pass++;
    n_chk++; if ({rec_dout[74], rec_dout[75], rec_dout[76], rec_dout[77]} !== 4'b0110) $display("FAIL b2b_boundary1: got %b exp 0110", {rec_dout[74], rec_dout[75], rec_dout[76], rec_dout[77]}); else n_pass++;
    n_chk++; if ({rec_dout[146], rec_dout[147], rec_dout[148]} !== 3'b011) $display("FAIL b2b_boundary2: got %b exp 011", {rec_dout[146], rec_dout[147], rec_dout[148]}); else n_pass++;
    n_chk++; if (count_high(3, 222) !== 98) $display("FAIL b2b_total_high: got %0d exp 98", count_high(3, 222)); else n_pass++;
  endtask

  task automatic test_degenerate();
    int dc, c1;
    mem[0] = 24'h000001; mem[1] = 24'h800000;
    set_timing(5, 3, 0, 0);
    run_frame(2, 1, 400, 0, 0, 0, dc);
    c1 = (rd_cyc.size() > 1) ? rd_cyc[1] : -1;
    n_chk++; if (dc !== 283) $display("FAIL degen_done_cycle: got %0d exp 283", dc); else n_pass++;
    n_chk++; if (count_high(3, 7) !== 5 || rec_dout[8] !== 1'b0) $display("FAIL degen_th_gt_ts: got %0d high exp 5", count_high(3, 7)); else n_pass++;
    n_chk++; if ({rec_dout[141], rec_dout[142]} !== 2'b10) $display("FAIL degen_zero_timing: got %b exp 10", {rec_dout[141], rec_dout[142]}); else n_pass++;
    n_chk++; if (c1 !== 141) $display("FAIL degen_prefetch: got %0d exp 141", c1); else n_pass++;
    n_chk++; if ({rec_dout[143], rec_dout[144], rec_dout[145], rec_dout[150]} !== 4'b1010) $display("FAIL degen_next_pixel: got %b exp 1010", {rec_dout[143], rec_dout[144], rec_dout[145], rec_dout[150]}); else n_pass++;
  endtask

  task automatic test_zero_pix();
    int dc;
    run_frame(0, 0, 20, 0, 0, 0, dc);
    n_chk++; if (dc !== 1) $display("FAIL zero_done_cycle: got %0d exp 1", dc); else n_pass++;
    n_chk++; if ({rec_busy[1], rec_busy[2], rec_done[2]} !== 3'b100) $display("FAIL zero_busy: got %b exp 100", {rec_busy[1], rec_busy[2], rec_done[2]}); else n_pass++;
    n_chk++; if (rd_cyc.size() !== 0 || count_high(1, 3) !== 0) $display("FAIL zero_no_activity: got reads %0d highs %0d exp 0/0", rd_cyc.size(), count_high(1, 3)); else n_pass++;
  endtask

  task automatic test_start_ignore();
    int dc, w;
    mem[0] = 24'h123456;
    set_timing(0, 0, 0, 0);
    run_frame(1, 3, 200, 20, 53, 54, dc);
    n_chk++; if (dc !== 53) $display("FAIL ign_done_cycle: got %0d exp 53", dc); else n_pass++;
    n_chk++; if (rec_rden[21] !== 1'b0) $display("FAIL ign_busy_start: got rd_en %b exp 0", rec_rden[21]); else n_pass++;
    n_chk++; if (rec_busy[54] !== 1'b0) $display("FAIL ign_done_start: got busy %b exp 0", rec_busy[54]); else n_pass++;
    n_chk++; if ({rec_busy[55], rec_rden[55]} !== 2'b11) $display("FAIL ign_reaccept: got %b exp 11", {rec_busy[55], rec_rden[55]}); else n_pass++;
    n_chk++; if (rd_cyc.size() !== 2) $display("FAIL ign_reads: got %0d exp 2", rd_cyc.size()); else n_pass++;
    w = 55;
    while (!done_o && w < 400) begin
      tick();
      w++;
    end
    n_chk++; if (w !== 107) $display("FAIL ign_second_done: got %0d exp 107", w); else n_pass++;
    tick(); tick();
  endtask

  task automatic test_clamp();
    int dc, la;
    set_timing(0, 0, 0, 0);
    run_frame(261, 1, 12400, 0, 0, 0, dc);
    la = (rd_adr.size() > 0) ? rd_adr[rd_adr.size() - 1] : -1;
    n_chk++; if (dc !== 12291) $display("FAIL clamp_done_cycle: got %0d exp 12291", dc); else n_pass++;
    n_chk++; if (rd_cyc.size() !== 256) $display("FAIL clamp_reads: got %0d exp 256", rd_cyc.size()); else n_pass++;
    n_chk++; if (la !== 255) $display("FAIL clamp_last_addr: got %0d exp 255", la); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dc, dseen;
    mem[0] = 24'hFFFFFF;
    set_timing(2, 6, 4, 6);
    pix_cnt_i = 9'd1;
    rst_cnt_i = 16'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_chk++; if ({dout_o ^ INV, busy_o} !== 2'b11) $display("FAIL rstmid_pre: got %b exp 11", {dout_o ^ INV, busy_o}); else n_pass++;
    #2 rst_i = 1'b1;
    #1;
    n_chk++; if ({dout_o ^ INV, rd_en_o, busy_o, done_o} !== 4'b0000) $display("FAIL rstmid_outputs: got %b exp 0000", {dout_o ^ INV, rd_en_o, busy_o, done_o}); else n_pass++;
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) dseen++;
    end
    rst_i = 1'b0;
    n_chk++; if (dseen !== 0) $display("FAIL rstmid_held: got %0d active cycles exp 0", dseen); else n_pass++;
    tick();
    run_frame(1, 2, 400, 0, 0, 0, dc);
    n_chk++; if (dc !== 148 || rec_dout[3] !== 1'b1) $display("FAIL rstmid_restart: got done %0d exp 148", dc); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 24'(i * 24'h010203);
    test_reset();
    test_one_pixel();
    test_back_to_back();
    test_degenerate();
    test_zero_pix();
    test_start_ignore();
    test_reset_mid();
    test_clamp();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ws281x_ctrl.md
# ws281x_ctrl

Frame sequencer for the WS281x LED output path. On a start pulse it reads pixels from a 24-bit pixel RAM, serializes them MSB-first into per-bit high/low waveforms using the programmable T0/T1 cycle counts, then holds the line low for a programmable latch (reset) period. It sits between the pixel RAM / register file and the LED data pin, and owns all frame-level sequencing.

## Interface
- ADDR_W, 8, pixel RAM address width; frame length up to 2^ADDR_W pixels.

- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  single-cycle frame start request
- pix_cnt_i  in  ADDR_W+1  pixels per frame; sampled on accepted start
- t0h_cnt_i / t0s_cnt_i  in  8 each  '0' bit high cycles / total bit period cycles
- t1h_cnt_i / t1s_cnt_i  in  8 each  '1' bit high cycles / total bit period cycles
- rst_cnt_i  in  16  latch low period in cycles; sampled on accepted start
- rd_en_o  out  1  pixel RAM read strobe
- rd_addr_o  out  ADDR_W  pixel RAM address
- rd_data_i  in  24  pixel data, valid exactly 1 cycle after rd_en_o
- dout_o  out  1  LED data line
- busy_o  out  1  frame in progress
- done_o  out  1  single-cycle frame completion pulse

## Operation
- States: IDLE, FETCH, WAIT, BIT, LATCH.
- IDLE: start_i=1 accepted; latch pix_cnt (clamped to 2^ADDR_W) and rst_cnt (0 treated as 1). pix_cnt=0 -> LATCH directly; else FETCH. start_i outside IDLE ignored.
- FETCH: rd_en_o=1, rd_addr_o=0 -> WAIT.
- WAIT: capture rd_data_i into shift register, bit index=23 -> BIT.
- BIT: per bit, select (th,ts) from current MSB: t1* if 1, t0* if 0; sampled in the bit's first cycle and held for that bit. th=0 treated as 1; effective period P=max(ts, th+1). dout_o high for th cycles, low for P-th cycles. Period counter 8-bit; no wrap possible since P<=256 handled with 9-bit compare.
- Prefetch: in the first cycle of bit 0 (last bit) of pixel n, if n+1 < pix_cnt: rd_en_o=1, rd_addr_o=n+1; rd_data_i captured next cycle into shadow register; shadow loads shift register at pixel boundary. Next pixel's first bit starts the cycle after previous bit ends: no gap.
- After last bit of last pixel -> LATCH: dout_o low for rst_cnt cycles, then done_o=1 for one cycle (last LATCH cycle), -> IDLE.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values; RAM read in flight discarded.

## Timing
- Reset values: dout_o=0, rd_en_o=0, rd_addr_o=0, busy_o=0, done_o=0; state IDLE.
- All outputs registered.
- Start sampled at edge E0: FETCH in cycle 1 (rd_en_o=1), WAIT cycle 2, dout_o rises cycle 3.
- busy_o=1 from cycle after accepted start through the done_o cycle inclusive; 0 from next cycle.
- Start asserted in the done_o cycle ignored; earliest re-accept is the following cycle.
- Frame length (pix_cnt=N>0) = 2 + sum(P over 24N bits) + rst_cnt cycles from start to done_o inclusive.
- Timing inputs may change freely; a change affects only bits starting afterwards.

## Configuration
- WS281X_CTRL_DOUT_INV_EN: defined -> dout_o driven inverted (reset value 1, high phase 0, latch 1) for inverting level shifters. Undefined -> polarity as described above. All other behaviour identical.

## Test plan
- Reset/idle: assert rst_i mid-BIT -> all outputs 0 same cycle; no done_o; new start after release works normally.
- One pixel 0xA50000, t0h=2,t0s=6,t1h=4,t1s=6, rst_cnt=10: dout rises cycle 3; first bit high 4/low 2, second high 2/low 4; 24 bits=144 cycles; done_o at cycle 2+144+10.
- Three pixels back-to-back: rd_en_o at addr 1 and 2 in first cycle of each pixel's last bit; no gap between pixel waveforms; exactly 3 reads.
- Degenerate timing: th=0,ts=0 -> 1 high/1 low per bit; th=5,ts=3 -> 5 high/1 low.
- pix_cnt=0, rst_cnt=0: no reads, dout stays 0, done_o 1 cycle after start, busy_o for 1 cycle.
- Start pulses during busy and in done cycle ignored; pix_cnt=2^ADDR_W+5 clamped to 2^ADDR_W reads.
